// File: rtl/efferent_spike_dispatcher.sv
// efferent_spike_dispatcher
//   Read side of the efferent weight matrix. When a spike is accepted, the block
//   scans row spike_tag, dst 0..numneurons-1, one column per cycle. It emits one
//   (dst_tag, weight) event per nonzero weight over a valid/ready handshake.
//   Zero weights mean "no connection" and are skipped.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   spike_valid/ready, spike_tag  spike input handshake (ready only in IDLE)
//   mem_src_tag, mem_dst_tag      row/column read address to the weight matrix
//   mem_weight                    combinational read data for that address
//   event_valid/ready             event output handshake
//   event_dst_tag, event_weight   event payload, held while stalled
//   busy                          scan or drain in progress
//   done                          one-cycle pulse after a row is fully dispatched
module efferent_spike_dispatcher #(
    parameter int numwidth   = 16,
    parameter int tagbits    = 1,
    parameter int numneurons = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spike_valid,
    input  logic [tagbits-1:0] spike_tag,
    output logic               spike_ready,
    output logic [tagbits-1:0] mem_src_tag,
    output logic [tagbits-1:0] mem_dst_tag,
    input  logic [numwidth:0]  mem_weight,
    output logic               event_valid,
    input  logic               event_ready,
    output logic [tagbits-1:0] event_dst_tag,
    output logic [numwidth:0]  event_weight,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [tagbits-1:0] src_q;
    logic [tagbits-1:0] dst_cnt;

    logic slot_free;
    logic nonzero;
    logic last;
    logic load;
    logic advance;
    logic finish;

    assign mem_src_tag = src_q;
    assign mem_dst_tag = dst_cnt;

    // The output register can take a new event if it is empty or being consumed now.
    assign slot_free = !event_valid || event_ready;
    // The sign bit alone still counts as a connection.
    assign nonzero   = |mem_weight;
    assign last      = (dst_cnt == tagbits'(numneurons - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        spike_ready = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                spike_ready = 1'b1;
                if (spike_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (!nonzero) begin
                    advance = 1'b1;
                end else if (slot_free) begin
                    load    = 1'b1;
                    advance = 1'b1;
                end
                if (advance && last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (slot_free) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q         <= '0;
            dst_cnt       <= '0;
            event_valid   <= 1'b0;
            event_dst_tag <= '0;
            event_weight  <= '0;
            done          <= 1'b0;
        end else begin
            done <= finish;

            if (state == IDLE && spike_valid) begin
                src_q   <= spike_tag;
                dst_cnt <= '0;
            end else if (advance && !last) begin
                dst_cnt <= dst_cnt + tagbits'(1);
            end else if (finish) begin
                dst_cnt <= '0;
            end

            if (load) begin
                event_valid   <= 1'b1;
                event_dst_tag <= dst_cnt;
                event_weight  <= mem_weight;
            end else if (event_ready) begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_efferent_spike_dispatcher.sv
// tb_efferent_spike_dispatcher
//   Directed bench for efferent_spike_dispatcher with tagbits=2, numneurons=4,
//   numwidth=16. A small combinational weight matrix answers the read address.
//   Cycle c=1 is the cycle right after the spike-accept edge.
module tb_efferent_spike_dispatcher;

    localparam int NW   = 16;
    localparam int TB   = 2;
    localparam int NN   = 4;
    localparam int MAXC = 20;

    logic          clk;
    logic          rst;
    logic          spike_valid;
    logic [TB-1:0] spike_tag;
    logic          spike_ready;
    logic [TB-1:0] mem_src_tag;
    logic [TB-1:0] mem_dst_tag;
    logic [NW:0]   mem_weight;
    logic          event_valid;
    logic          event_ready;
    logic [TB-1:0] event_dst_tag;
    logic [NW:0]   event_weight;
    logic          busy;
    logic          done;

    logic [NW:0] wmem [NN][NN];
    assign mem_weight = wmem[mem_src_tag][mem_dst_tag];

    efferent_spike_dispatcher #(
        .numwidth  (NW),
        .tagbits   (TB),
        .numneurons(NN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spike_valid  (spike_valid),
        .spike_tag    (spike_tag),
        .spike_ready  (spike_ready),
        .mem_src_tag  (mem_src_tag),
        .mem_dst_tag  (mem_dst_tag),
        .mem_weight   (mem_weight),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_dst_tag(event_dst_tag),
        .event_weight (event_weight),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Per-cycle history of one row run
    logic          v_h   [MAXC+1];
    logic [TB-1:0] d_h   [MAXC+1];
    logic [NW:0]   w_h   [MAXC+1];
    logic [TB-1:0] dst_h [MAXC+1];
    logic [TB-1:0] src_h [MAXC+1];
    logic          sr_h  [MAXC+1];
    logic [TB-1:0] ev_d  [MAXC+1];
    logic [NW:0]   ev_w  [MAXC+1];
    int            nev;
    int            busy_cnt;
    int            vcnt;
    int            dc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [TB-1:0] t);
        spike_tag   = t;
        spike_valid = 1'b1;
        #1;
        check("accept_ready", {31'd0, spike_ready}, 32'd1);
        @(posedge clk);
        #1;
        spike_valid = 1'b0;
    endtask

    // Runs from cycle 1 until done is seen (or MAXC expires, leaving done_c=0).
    // Bit c of rdy_low holds event_ready low in cycle c.
    task automatic run_row(input logic [31:0] rdy_low, output int done_c);
        done_c   = 0;
        nev      = 0;
        busy_cnt = 0;
        vcnt     = 0;
        for (int c = 1; c <= MAXC; c++) begin
            event_ready = !rdy_low[c];
            #1;
            v_h[c]   = event_valid;
            d_h[c]   = event_dst_tag;
            w_h[c]   = event_weight;
            dst_h[c] = mem_dst_tag;
            src_h[c] = mem_src_tag;
            sr_h[c]  = spike_ready;
            if (busy) busy_cnt++;
            if (event_valid) vcnt++;
            if (event_valid && event_ready) begin
                ev_d[nev] = event_dst_tag;
                ev_w[nev] = event_weight;
                nev++;
            end
            if (done) begin
                done_c = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        event_ready = 1'b1;
    endtask

    initial begin
        for (int r = 0; r < NN; r++)
            for (int d = 0; d < NN; d++)
                wmem[r][d] = '0;
        wmem[0][0] = 17'd3;
        wmem[0][1] = 17'd4;
        wmem[0][2] = 17'd7;
        wmem[0][3] = 17'd9;
        wmem[1][1] = 17'd5;
        wmem[1][3] = 17'h1FFFF;
        wmem[3][0] = 17'h10000;

        rst         = 1'b1;
        spike_valid = 1'b0;
        spike_tag   = '0;
        event_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_spike_ready", {31'd0, spike_ready}, 32'd1);
        check("rst_busy",        {31'd0, busy}, 32'd0);
        check("rst_done",        {31'd0, done}, 32'd0);
        check("rst_event_valid", {31'd0, event_valid}, 32'd0);
        check("rst_event_dst",   {30'd0, event_dst_tag}, 32'd0);
        check("rst_event_wt",    {15'd0, event_weight}, 32'd0);
        check("rst_src",         {30'd0, mem_src_tag}, 32'd0);
        check("rst_dst",         {30'd0, mem_dst_tag}, 32'd0);
        @(posedge clk);
        #1;

        // Row 1 = {0,5,0,1FFFF}, ready held high
        accept(2'd1);
        run_row(32'd0, dc);
        check("t1_src_c1",   {30'd0, src_h[1]}, 32'd1);
        check("t1_dst_c1",   {30'd0, dst_h[1]}, 32'd0);
        check("t1_v_c2",     {31'd0, v_h[2]}, 32'd0);
        check("t1_done_c",   dc, 32'd6);
        check("t1_nev",      nev, 32'd2);
        check("t1_ev0_dst",  {30'd0, ev_d[0]}, 32'd1);
        check("t1_ev0_wt",   {15'd0, ev_w[0]}, 32'd5);
        check("t1_ev1_dst",  {30'd0, ev_d[1]}, 32'd3);
        check("t1_ev1_wt",   {15'd0, ev_w[1]}, 32'h1FFFF);
        check("t1_busy_cnt", busy_cnt, 32'd5);
        @(posedge clk);
        #1;
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_idle_busy",  {31'd0, busy}, 32'd0);

        // Row 2 all zero
        accept(2'd2);
        run_row(32'd0, dc);
        check("t2_done_c",   dc, 32'd6);
        check("t2_nev",      nev, 32'd0);
        check("t2_vcnt",     vcnt, 32'd0);
        check("t2_busy_cnt", busy_cnt, 32'd5);
        @(posedge clk);
        #1;
        check("t2_done_pulse", {31'd0, done}, 32'd0);

        // Row 0 = {3,4,7,9}, ready low in cycles 2..4
        accept(2'd0);
        run_row(32'h0000_001C, dc);
        check("t3_done_c", dc, 32'd9);
        check("t3_nev",    nev, 32'd4);
        check("t3_ev0_dst", {30'd0, ev_d[0]}, 32'd0);
        check("t3_ev0_wt",  {15'd0, ev_w[0]}, 32'd3);
        check("t3_ev1_dst", {30'd0, ev_d[1]}, 32'd1);
        check("t3_ev1_wt",  {15'd0, ev_w[1]}, 32'd4);
        check("t3_ev2_dst", {30'd0, ev_d[2]}, 32'd2);
        check("t3_ev2_wt",  {15'd0, ev_w[2]}, 32'd7);
        check("t3_ev3_dst", {30'd0, ev_d[3]}, 32'd3);
        check("t3_ev3_wt",  {15'd0, ev_w[3]}, 32'd9);
        for (int c = 2; c <= 4; c++) begin
            check("t3_hold_valid", {31'd0, v_h[c]}, 32'd1);
            check("t3_hold_dst",   {30'd0, d_h[c]}, 32'd0);
            check("t3_hold_wt",    {15'd0, w_h[c]}, 32'd3);
            check("t3_stall_cnt",  {30'd0, dst_h[c]}, 32'd1);
        end
        @(posedge clk);
        #1;

        // Second spike (tag 3) held during a row-2 scan, taken on the done cycle
        spike_tag   = 2'd2;
        spike_valid = 1'b1;
        #1;
        check("t4_accept_ready", {31'd0, spike_ready}, 32'd1);
        @(posedge clk);
        #1;
        spike_tag = 2'd3;
        run_row(32'd0, dc);
        check("t4_done_c", dc, 32'd6);
        begin
            int srcnt;
            srcnt = 0;
            for (int c = 1; c <= 5; c++)
                if (sr_h[c]) srcnt++;
            check("t4_ready_while_busy", srcnt, 32'd0);
        end
        check("t4_ready_at_done", {31'd0, sr_h[6]}, 32'd1);
        @(posedge clk);
        #1;
        spike_valid = 1'b0;

        // Row 3 = {10000,0,0,0}: sign-only weight is a connection
        run_row(32'd0, dc);
        check("t6_src_c1", {30'd0, src_h[1]}, 32'd3);
        check("t6_busy",   busy_cnt, 32'd5);
        check("t6_done_c", dc, 32'd6);
        check("t6_nev",    nev, 32'd1);
        check("t6_ev0_dst", {30'd0, ev_d[0]}, 32'd0);
        check("t6_ev0_wt",  {15'd0, ev_w[0]}, 32'h10000);
        @(posedge clk);
        #1;

        // Reset while an event is pending in SCAN
        event_ready = 1'b0;
        accept(2'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("t5_pending_valid", {31'd0, event_valid}, 32'd1);
        check("t5_pending_dst",   {30'd0, event_dst_tag}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_valid_cleared", {31'd0, event_valid}, 32'd0);
        check("t5_busy",          {31'd0, busy}, 32'd0);
        check("t5_spike_ready",   {31'd0, spike_ready}, 32'd1);
        check("t5_done",          {31'd0, done}, 32'd0);
        check("t5_src",           {30'd0, mem_src_tag}, 32'd0);
        check("t5_dst",           {30'd0, mem_dst_tag}, 32'd0);
        rst         = 1'b0;
        event_ready = 1'b1;
        begin
            int dseen;
            dseen = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (done) dseen++;
            end
            check("t5_no_done", dseen, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
